wb_commit_queue: RTL and testbench

//  Parametrised writeback commit stage: collects register-write results from NUM_SRC

---
 rtl/wb_commit_queue.sv | 98 +++++++++
 tb/tb_wb_commit_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: arbitrates NUM_SRC register-write producers into an in-order
// DEPTH-entry queue drained one entry per granted cycle, with youngest-match forwarding.
module wb_commit_queue #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*AW-1:0]   src_adr,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic                    rf_grant,
  output logic                    regw_enable,
  output logic [AW-1:0]           regw_adr,
  output logic [XLEN-1:0]         reg_write,
  input  logic [AW-1:0]           fwd_adr,
  output logic                    fwd_hit,
  output logic [XLEN-1:0]         fwd_data,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic                    empty
);
  logic [AW-1:0]   adr_q  [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]   rd_ptr, wr_ptr, idx;
  logic [AW-1:0]   win_adr;
  logic [XLEN-1:0] win_data;
  logic            pop, space, push_real;

  assign empty       = count == '0;
  assign full        = count == CW'(DEPTH);
  assign pop         = rf_grant & ~empty;
  assign space       = ~full | pop;
  assign push_real   = |src_ready & |win_adr;
  assign regw_enable = ~empty;
  assign regw_adr    = empty ? '0 : adr_q[rd_ptr];
  assign reg_write   = empty ? '0 : data_q[rd_ptr];

  // Scan high to low so the lowest-numbered valid channel is the final winner.
  always_comb begin
    src_ready = '0;
    win_adr   = '0;
    win_data  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        src_ready    = '0;
        src_ready[i] = space;
        win_adr      = src_adr[i*AW +: AW];
        win_data     = src_data[i*XLEN +: XLEN];
      end
    end
  end

  // Walk oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (vld_q[idx] && adr_q[idx] == fwd_adr && |fwd_adr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        adr_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push_real) begin
        adr_q[wr_ptr]  <= win_adr;
        data_q[wr_ptr] <= win_data;
        vld_q[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      count <= count + CW'(push_real) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_wb_commit_queue.sv
// tb_wb_commit_queue: directed plus randomized traffic against a queue-based reference model.
module tb_wb_commit_queue;
  localparam int XLEN = 32, AW = 5, NUM_SRC = 2, DEPTH = 4, CW = $clog2(DEPTH) + 1;
  logic                    clk = 1'b0, reset = 1'b0, rf_grant = 1'b0;
  logic [NUM_SRC-1:0]      src_valid = '0, src_ready, acc;
  logic [NUM_SRC*AW-1:0]   src_adr = '0;
  logic [NUM_SRC*XLEN-1:0] src_data = '0;
  logic                    regw_enable, fwd_hit, full, empty;
  logic [AW-1:0]           regw_adr, fwd_adr = '0;
  logic [XLEN-1:0]         reg_write, fwd_data;
  logic [CW-1:0]           count;
  logic [AW+XLEN-1:0]      mq[$];
  int checks = 0, failures = 0;

  wb_commit_queue #(.XLEN(XLEN), .AW(AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_adr(src_adr), .src_data(src_data),
    .src_ready(src_ready), .rf_grant(rf_grant), .regw_enable(regw_enable), .regw_adr(regw_adr),
    .reg_write(reg_write), .fwd_adr(fwd_adr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .full(full), .empty(empty));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ch, input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    src_valid[ch] = v;
    src_adr[ch*AW +: AW] = a;
    src_data[ch*XLEN +: XLEN] = d;
  endtask

  // Check every output against the model, then advance one clock and update the model.
  task automatic cyc();
    int w;
    logic sp, hit;
    logic [NUM_SRC-1:0] er;
    logic [AW-1:0] wa;
    logic [XLEN-1:0] wd, fd;
    #1;
    sp = mq.size() < DEPTH || (rf_grant && mq.size() > 0);
    er = '0;
    w = -1;
    for (int i = 0; i < NUM_SRC; i++) if (src_valid[i] && w < 0) w = i;
    if (w >= 0) er[w] = sp;
    hit = 1'b0;
    fd = '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (!hit && fwd_adr != 0 && mq[i][AW+XLEN-1:XLEN] == fwd_adr) begin
        hit = 1'b1;
        fd = mq[i][XLEN-1:0];
      end
    chk("src_ready", 64'(src_ready), 64'(er));
    chk("regw_enable", 64'(regw_enable), 64'(mq.size() > 0));
    chk("regw_adr", 64'(regw_adr), mq.size() > 0 ? 64'(mq[0][AW+XLEN-1:XLEN]) : 64'(0));
    chk("reg_write", 64'(reg_write), mq.size() > 0 ? 64'(mq[0][XLEN-1:0]) : 64'(0));
    chk("count", 64'(count), 64'(mq.size()));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("fwd_hit", 64'(fwd_hit), 64'(hit));
    chk("fwd_data", 64'(fwd_data), 64'(fd));
    acc = er & src_valid;
    if (w >= 0) begin
      wa = src_adr[w*AW +: AW];
      wd = src_data[w*XLEN +: XLEN];
    end
    @(posedge clk);
    if (rf_grant && mq.size() > 0) void'(mq.pop_front());
    if (w >= 0 && sp && wa != 0) mq.push_back({wa, wd});
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cyc();
    // ch0 single write, granted immediately
    rf_grant = 1'b1;
    drive(0, 1'b1, 5'd8, 32'h11);
    cyc();
    drive(0, 1'b0, '0, '0);
    cyc();
    cyc();
    // both channels at once: ch0 first, then ch1
    rf_grant = 1'b0;
    drive(0, 1'b1, 5'd3, 32'hA);
    drive(1, 1'b1, 5'd4, 32'hB);
    cyc();
    drive(0, 1'b0, '0, '0);
    cyc();
    drive(1, 1'b0, '0, '0);
    rf_grant = 1'b1;
    repeat (3) cyc();
    // fill, blocked push, then push and pop on the same edge
    rf_grant = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1'b1, AW'(i), XLEN'(32'h100 + i));
      cyc();
    end
    drive(0, 1'b1, 5'd9, 32'h99);
    cyc();
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b1, 5'd10, 32'hAA);
    rf_grant = 1'b1;
    cyc();
    drive(1, 1'b0, '0, '0);
    rf_grant = 1'b0;
    cyc();
    rf_grant = 1'b1;
    repeat (5) cyc();
    // forwarding: youngest match wins, r0 never hits, popping head still visible
    rf_grant = 1'b0;
    drive(0, 1'b1, 5'd5, 32'h1);
    cyc();
    drive(0, 1'b1, 5'd5, 32'h2);
    cyc();
    drive(0, 1'b1, 5'd6, 32'h3);
    cyc();
    drive(0, 1'b0, '0, '0);
    fwd_adr = 5'd5;
    cyc();
    fwd_adr = 5'd0;
    cyc();
    fwd_adr = 5'd7;
    cyc();
    fwd_adr = 5'd5;
    rf_grant = 1'b1;
    repeat (4) cyc();
    // write to r0 handshakes but is dropped
    rf_grant = 1'b0;
    drive(0, 1'b1, 5'd0, 32'hFFFF);
    cyc();
    drive(0, 1'b0, '0, '0);
    cyc();
    // async reset with three entries held
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, AW'(20 + i), XLEN'(i + 7));
      cyc();
    end
    drive(0, 1'b0, '0, '0);
    fwd_adr = 5'd21;
    #2 reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_regw_enable", 64'(regw_enable), 64'(0));
    chk("rst_regw_adr", 64'(regw_adr), 64'(0));
    chk("rst_reg_write", 64'(reg_write), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_fwd_hit", 64'(fwd_hit), 64'(0));
    mq.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    cyc();
    // randomized traffic; producers hold until accepted
    acc = '0;
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < NUM_SRC; c++)
        if (acc[c] || !src_valid[c])
          drive(c, 1'($urandom_range(1, 0)), AW'($urandom_range(31, 0)), $urandom);
      rf_grant = 1'($urandom_range(2, 0) != 0);
      fwd_adr = AW'($urandom_range(31, 0));
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
